irr_unit: RTL and testbench

IRR_UNIT -- requirements
Module: irr_unit

---
 rtl/irr_unit.sv | 56 +++++
 tb/tb_irr_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/irr_unit.sv
// Interrupt request register: latches IR lines (edge or level mode) and
// clears the acknowledged bit on the first clock of each first-INTA pulse.
module irr_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       LTIM,
    input  logic [7:0] IRBus,
    input  logic [2:0] highestPriority,
    input  logic       INTA,
    input  logic       currentPulse,
    output logic [7:0] irr
);

    logic [7:0] r_irr;
    logic [7:0] r_ir_prev;
    logic       r_inta_prev;

    logic       w_ack;
    logic [7:0] w_ack_mask;
    logic [7:0] w_set;
    logic [7:0] w_irr_next;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        logic [7:0] res;
        res      = 8'h00;
        res[idx] = 1'b1;
        return res;
    endfunction

    // Only the falling INTA edge of the first pulse acknowledges; clear beats set.
    always_comb begin
        w_ack      = ~INTA & r_inta_prev & currentPulse;
        w_ack_mask = w_ack ? onehot8(highestPriority) : 8'h00;
        w_set      = IRBus & ~r_ir_prev;
        if (LTIM) begin
            w_irr_next = IRBus & ~w_ack_mask;
        end else begin
            w_irr_next = (r_irr | w_set) & ~w_ack_mask;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irr       <= 8'h00;
            r_ir_prev   <= 8'h00;
            r_inta_prev <= 1'b1;
        end else begin
            r_irr       <= w_irr_next;
            r_ir_prev   <= IRBus;
            r_inta_prev <= INTA;
        end
    end

    assign irr = r_irr;

endmodule

// File: tb/tb_irr_unit.sv
// Bench for irr_unit: table-driven vectors through a scoreboard queue, plus
// hand-written asynchronous reset sequences.
module tb_irr_unit;

    logic       clk;
    logic       reset;
    logic       LTIM;
    logic [7:0] IRBus;
    logic [2:0] highestPriority;
    logic       INTA;
    logic       currentPulse;
    logic [7:0] irr;

    irr_unit dut (
        .clk             (clk),
        .reset           (reset),
        .LTIM            (LTIM),
        .IRBus           (IRBus),
        .highestPriority (highestPriority),
        .INTA            (INTA),
        .currentPulse    (currentPulse),
        .irr             (irr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ltim;
        logic [7:0] ir;
        logic [2:0] hp;
        logic       inta;
        logic       cp;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl_a[$];
    vec_t       tbl_b[$];
    logic [7:0] sb_q[$];
    int         n_checks;
    int         n_pass;

    function automatic vec_t mk(input logic ltim, input logic [7:0] ir, input logic [2:0] hp,
                                input logic inta, input logic cp, input logic [7:0] exp);
        vec_t v;
        v.ltim = ltim;
        v.ir   = ir;
        v.hp   = hp;
        v.inta = inta;
        v.cp   = cp;
        v.exp  = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: irr=%02h expected=%02h", name, act, req);
        end
    endtask

    task automatic apply(input string tag, input int idx, input vec_t v);
        logic [7:0] exp_v;
        @(negedge clk);
        LTIM            = v.ltim;
        IRBus           = v.ir;
        highestPriority = v.hp;
        INTA            = v.inta;
        currentPulse    = v.cp;
        sb_q.push_back(v.exp);
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        check($sformatf("%s%0d", tag, idx), irr, exp_v);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Edge mode: accumulate, acknowledge, re-arm, simultaneous set/clear
        tbl_a.push_back(mk(0, 8'h00, 3'd0, 1, 0, 8'h00));
        tbl_a.push_back(mk(0, 8'h00, 3'd0, 1, 0, 8'h00));
        tbl_a.push_back(mk(0, 8'h01, 3'd0, 1, 0, 8'h01));
        tbl_a.push_back(mk(0, 8'h01, 3'd0, 1, 0, 8'h01));
        tbl_a.push_back(mk(0, 8'h02, 3'd0, 1, 0, 8'h03));
        tbl_a.push_back(mk(0, 8'h02, 3'd0, 1, 0, 8'h03));
        tbl_a.push_back(mk(0, 8'h04, 3'd0, 1, 0, 8'h07));
        tbl_a.push_back(mk(0, 8'h08, 3'd0, 1, 0, 8'h0F));
        tbl_a.push_back(mk(0, 8'h10, 3'd0, 1, 0, 8'h1F));
        tbl_a.push_back(mk(0, 8'h20, 3'd0, 1, 0, 8'h3F));
        tbl_a.push_back(mk(0, 8'h20, 3'd0, 1, 0, 8'h3F));
        tbl_a.push_back(mk(0, 8'h20, 3'd5, 0, 1, 8'h1F));
        tbl_a.push_back(mk(0, 8'h20, 3'd5, 0, 1, 8'h1F));
        tbl_a.push_back(mk(0, 8'h20, 3'd5, 1, 1, 8'h1F));
        tbl_a.push_back(mk(0, 8'h00, 3'd5, 1, 1, 8'h1F));
        tbl_a.push_back(mk(0, 8'h20, 3'd5, 1, 1, 8'h3F));
        tbl_a.push_back(mk(0, 8'h00, 3'd5, 1, 1, 8'h3F));
        tbl_a.push_back(mk(0, 8'h60, 3'd5, 0, 1, 8'h5F));
        tbl_a.push_back(mk(0, 8'h60, 3'd5, 1, 1, 8'h5F));

        // After mid-run reset: second-pulse acks ignored, level mode, mode switches
        tbl_b.push_back(mk(0, 8'h01, 3'd0, 1, 0, 8'h01));
        tbl_b.push_back(mk(0, 8'hC1, 3'd0, 1, 0, 8'hC1));
        tbl_b.push_back(mk(0, 8'hC1, 3'd0, 1, 0, 8'hC1));
        tbl_b.push_back(mk(0, 8'hC1, 3'd0, 0, 0, 8'hC1));
        tbl_b.push_back(mk(0, 8'hC1, 3'd0, 0, 0, 8'hC1));
        tbl_b.push_back(mk(0, 8'hC1, 3'd0, 1, 0, 8'hC1));
        tbl_b.push_back(mk(0, 8'hC1, 3'd0, 0, 1, 8'hC0));
        tbl_b.push_back(mk(0, 8'hC1, 3'd0, 1, 0, 8'hC0));
        tbl_b.push_back(mk(1, 8'hC1, 3'd0, 1, 0, 8'hC1));
        for (int i = 0; i < 8; i++) begin
            logic [7:0] oh;
            oh = 8'h01 << i;
            tbl_b.push_back(mk(1, oh, 3'd0, 1, 0, oh));
        end
        tbl_b.push_back(mk(1, 8'h20, 3'd0, 1, 0, 8'h20));
        tbl_b.push_back(mk(1, 8'h20, 3'd5, 0, 1, 8'h00));
        tbl_b.push_back(mk(1, 8'h20, 3'd5, 0, 1, 8'h20));
        tbl_b.push_back(mk(1, 8'h20, 3'd5, 1, 0, 8'h20));
        tbl_b.push_back(mk(0, 8'h20, 3'd0, 1, 0, 8'h20));
        tbl_b.push_back(mk(0, 8'h00, 3'd0, 1, 0, 8'h20));
        tbl_b.push_back(mk(1, 8'h00, 3'd0, 1, 0, 8'h00));
        tbl_b.push_back(mk(1, 8'h0F, 3'd0, 1, 0, 8'h0F));
        tbl_b.push_back(mk(1, 8'h0F, 3'd2, 0, 1, 8'h0B));
        tbl_b.push_back(mk(1, 8'h0F, 3'd2, 1, 0, 8'h0F));
        tbl_b.push_back(mk(0, 8'h0F, 3'd0, 1, 0, 8'h0F));
        tbl_b.push_back(mk(0, 8'h1F, 3'd0, 1, 0, 8'h1F));

        reset           = 1'b0;
        LTIM            = 1'b0;
        IRBus           = 8'h00;
        highestPriority = 3'd0;
        INTA            = 1'b1;
        currentPulse    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", irr, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl_a[i]) apply("edge_vec", i, tbl_a[i]);

        // Asynchronous reset between clocks, then IR line already high at release
        #2;
        reset = 1'b0;
        IRBus = 8'h01;
        #1;
        check("async_clear", irr, 8'h00);
        @(posedge clk);
        #1;
        check("reset_held", irr, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl_b[i]) apply("vec_b", i, tbl_b[i]);

        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
